// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder slice.
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

endpackage

// File: rtl/nibble_serial_add_16_if.sv
// Operand/result handshake bundle for nibble_serial_add_16.
interface nibble_serial_add_16_if
  import adder_pkg::*;
#(
  parameter int NIBBLES = 4
);

  localparam int W = NIBBLES * NIBBLE_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;

  modport master (
    output in_valid, a, b, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry_out
  );

  modport slave (
    input  in_valid, a, b, carry_in, out_ready,
    output in_ready, out_valid, sum, carry_out
  );

endinterface

// File: rtl/ripple_add_4bit_dataflow.sv
// 4-bit ripple-carry adder slice: full-adder equations chained LSB to MSB.
module ripple_add_4bit_dataflow
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                c_i,
  output logic [NIBBLE_W-1:0] s_o,
  output logic                c_o
);

  logic carry;

  // Carry kept in a scalar walked through the bits so no vector feeds itself.
  always_comb begin
    s_o   = '0;
    carry = c_i;
    for (int unsigned i = 0; i < NIBBLE_W; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    c_o = carry;
  end

endmodule

// File: rtl/nibble_serial_add_16.sv
// Nibble-serial adder: captures a/b/carry_in, adds one nibble per cycle
// through a single 4-bit slice, and holds the result until consumed.
module nibble_serial_add_16
  import adder_pkg::*;
#(
  parameter int NIBBLES = 4
)(
  input logic                   clk,
  input logic                   rst,
  nibble_serial_add_16_if.slave bus
);

  localparam int                W        = NIBBLES * NIBBLE_W;
  localparam int                IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 carry_q, carry_d;
  logic [W-1:0]         a_q, a_d;
  logic [W-1:0]         b_q, b_d;
  logic [W-1:0]         sum_q, sum_d;
  logic                 cout_q, cout_d;

  logic [NIBBLE_W-1:0]  nib_a, nib_b, nib_s;
  logic                 nib_co;

  // Nibble select as an explicit mux so idx can never reach past the top slice.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_a = a_q[i*NIBBLE_W +: NIBBLE_W];
        nib_b = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  ripple_add_4bit_dataflow u_slice (
    .a_i (nib_a),
    .b_i (nib_b),
    .c_i (carry_q),
    .s_o (nib_s),
    .c_o (nib_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.carry_in;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        for (int unsigned i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[i*NIBBLE_W +: NIBBLE_W] = nib_s;
          end
        end
        carry_d = nib_co;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          cout_d  = nib_co;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;

endmodule
